// File: rtl/id_stage.sv
// id_stage: ARM decode stage with the 16x32 register file,
// NZCV condition check and source indices for the hazard unit.
module id_stage #(
    parameter int REG_INIT_INDEX = 0,
    parameter int BYPASS_EN      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] instruction_in,
    input  logic [3:0]  status_in,
    input  logic        hazard,
    input  logic        wb_en_in,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic [31:0] pc_out,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        b,
    output logic        s,
    output logic [3:0]  exe_cmd,
    output logic [31:0] val_rn,
    output logic [31:0] val_rm,
    output logic        imm,
    output logic [11:0] shift_operand,
    output logic [23:0] signed_imm_24,
    output logic [3:0]  dest,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic        two_src
);

    localparam logic BYP = (BYPASS_EN != 0);

    logic [31:0] r_regs [16];

    logic [3:0] w_cond;
    logic [1:0] w_mode;
    logic [3:0] w_op;
    logic       w_sbit;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond_pass;
    logic [3:0] w_cmd;
    logic       w_wb, w_mr, w_mw, w_b, w_s;
    logic       w_is_str;
    logic       w_bubble;
    logic [3:0] w_src1, w_src2;
    logic       w_byp_rn, w_byp_rm;

    assign w_cond = instruction_in[31:28];
    assign w_mode = instruction_in[27:26];
    assign w_op   = instruction_in[24:21];
    assign w_sbit = instruction_in[20];
    assign {w_n, w_z, w_c, w_v} = status_in;

    // Evaluate the condition field against the current flags
    always_comb begin
        w_cond_pass = 1'b0;
        case (w_cond)
            4'h0:    w_cond_pass = w_z;
            4'h1:    w_cond_pass = ~w_z;
            4'h2:    w_cond_pass = w_c;
            4'h3:    w_cond_pass = ~w_c;
            4'h4:    w_cond_pass = w_n;
            4'h5:    w_cond_pass = ~w_n;
            4'h6:    w_cond_pass = w_v;
            4'h7:    w_cond_pass = ~w_v;
            4'h8:    w_cond_pass = w_c & ~w_z;
            4'h9:    w_cond_pass = ~w_c | w_z;
            4'hA:    w_cond_pass = (w_n == w_v);
            4'hB:    w_cond_pass = (w_n != w_v);
            4'hC:    w_cond_pass = ~w_z & (w_n == w_v);
            4'hD:    w_cond_pass = w_z | (w_n != w_v);
            4'hE:    w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    // Raw control decode, before the bubble is applied
    always_comb begin
        w_cmd = 4'd0;
        w_wb  = 1'b0;
        w_mr  = 1'b0;
        w_mw  = 1'b0;
        w_b   = 1'b0;
        w_s   = 1'b0;
        unique case (w_mode)
            2'b00: begin
                w_wb = 1'b1;
                w_s  = w_sbit;
                case (w_op)
                    4'b1101: w_cmd = 4'b0001;
                    4'b1111: w_cmd = 4'b1001;
                    4'b0100: w_cmd = 4'b0010;
                    4'b0101: w_cmd = 4'b0011;
                    4'b0010: w_cmd = 4'b0100;
                    4'b0110: w_cmd = 4'b0101;
                    4'b0000: w_cmd = 4'b0110;
                    4'b1100: w_cmd = 4'b0111;
                    4'b0001: w_cmd = 4'b1000;
                    4'b1010: begin
                        w_cmd = 4'b0100;
                        w_wb  = 1'b0;
                    end
                    4'b1000: begin
                        w_cmd = 4'b0110;
                        w_wb  = 1'b0;
                    end
                    default: begin
                        w_wb = 1'b0;
                        w_s  = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                w_cmd = 4'b0010;
                if (w_sbit) begin
                    w_mr = 1'b1;
                    w_wb = 1'b1;
                end else begin
                    w_mw = 1'b1;
                end
            end
            2'b10: w_b = 1'b1;
            2'b11: ;
        endcase
    end

    // Register file: async reset to init contents, write on clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= (REG_INIT_INDEX != 0) ? 32'(i) : 32'd0;
            end
        end else if (wb_en_in) begin
            r_regs[wb_dest] <= wb_value;
        end
    end

    assign w_is_str = (w_mode == 2'b01) & ~w_sbit;
    assign w_src1   = instruction_in[19:16];
    assign w_src2   = w_is_str ? instruction_in[15:12]
                               : instruction_in[3:0];

    assign w_bubble = hazard | ~w_cond_pass
                    | (instruction_in == 32'd0);

    assign w_byp_rn = BYP & ~rst & wb_en_in & (wb_dest == w_src1);
    assign w_byp_rm = BYP & ~rst & wb_en_in & (wb_dest == w_src2);

    assign val_rn = w_byp_rn ? wb_value : r_regs[w_src1];
    assign val_rm = w_byp_rm ? wb_value : r_regs[w_src2];

    assign pc_out        = pc_in;
    assign wb_en         = w_wb & ~w_bubble;
    assign mem_r_en      = w_mr & ~w_bubble;
    assign mem_w_en      = w_mw & ~w_bubble;
    assign b             = w_b  & ~w_bubble;
    assign s             = w_s  & ~w_bubble;
    assign exe_cmd       = w_bubble ? 4'd0 : w_cmd;
    assign imm           = instruction_in[25];
    assign shift_operand = instruction_in[11:0];
    assign signed_imm_24 = instruction_in[23:0];
    assign dest          = instruction_in[15:12];
    assign src1          = w_src1;
    assign src2          = w_src2;
    assign two_src       = ~instruction_in[25] | w_is_str;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: vector table, hand sequences and a randomized
// run against a spec-level model of the decode stage.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, instruction_in;
    logic [3:0]  status_in;
    logic        hazard, wb_en_in;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [31:0] pc_out;
    logic        wb_en, mem_r_en, mem_w_en, b, s;
    logic [3:0]  exe_cmd;
    logic [31:0] val_rn, val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest, src1, src2;
    logic        two_src;

    id_stage #(.REG_INIT_INDEX(1), .BYPASS_EN(1)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in),
        .instruction_in(instruction_in), .status_in(status_in),
        .hazard(hazard), .wb_en_in(wb_en_in), .wb_dest(wb_dest),
        .wb_value(wb_value), .pc_out(pc_out), .wb_en(wb_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s),
        .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm),
        .imm(imm), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .dest(dest), .src1(src1),
        .src2(src2), .two_src(two_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  st;
        logic        hz;
        logic [3:0]  cmd;
        logic        wb, mr, mw, br, sf, two;
        logic [31:0] rn, rm;
    } vec_t;

    vec_t        tbl[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_regs [16];
    logic [3:0]  dp_cmd [16];
    bit          dp_ok [16];
    bit          dp_wb [16];
    logic [31:0] r;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h",
                      nm, act, exp);
    endtask

    task automatic dp(input logic [3:0] op, input logic [3:0] cmd,
                      input bit wb);
        dp_ok[op]  = 1'b1;
        dp_cmd[op] = cmd;
        dp_wb[op]  = wb;
    endtask

    function automatic bit cond_ok(input logic [3:0] c,
                                   input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rd(input logic [3:0] idx);
        if (!rst && wb_en_in && wb_dest == idx) return wb_value;
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'(i);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst && wb_en_in) m_regs[wb_dest] = wb_value;
        @(negedge clk);
    endtask

    task automatic check_all(input string t);
        logic [31:0] ins;
        logic [3:0]  cmd, s2;
        bit          wb, mr, mw, br, sf, go, str;
        ins = instruction_in;
        cmd = 4'd0; wb = 0; mr = 0; mw = 0; br = 0; sf = 0;
        str = (ins[27:26] == 2'b01) && !ins[20];
        case (ins[27:26])
            2'b00: if (dp_ok[ins[24:21]]) begin
                cmd = dp_cmd[ins[24:21]];
                wb  = dp_wb[ins[24:21]];
                sf  = ins[20];
            end
            2'b01: begin
                cmd = 4'h2;
                if (ins[20]) begin mr = 1; wb = 1; end
                else mw = 1;
            end
            2'b10: br = 1;
            default: ;
        endcase
        go = !hazard && cond_ok(ins[31:28], status_in) && ins != 0;
        s2 = str ? ins[15:12] : ins[3:0];
        chk({t, ".pc"}, pc_out, pc_in);
        chk({t, ".wb"}, 32'(wb_en), 32'(go && wb));
        chk({t, ".mr"}, 32'(mem_r_en), 32'(go && mr));
        chk({t, ".mw"}, 32'(mem_w_en), 32'(go && mw));
        chk({t, ".b"}, 32'(b), 32'(go && br));
        chk({t, ".s"}, 32'(s), 32'(go && sf));
        chk({t, ".cmd"}, 32'(exe_cmd), go ? 32'(cmd) : 32'd0);
        chk({t, ".imm"}, 32'(imm), 32'(ins[25]));
        chk({t, ".sh"}, 32'(shift_operand), 32'(ins[11:0]));
        chk({t, ".si"}, 32'(signed_imm_24), 32'(ins[23:0]));
        chk({t, ".dest"}, 32'(dest), 32'(ins[15:12]));
        chk({t, ".src1"}, 32'(src1), 32'(ins[19:16]));
        chk({t, ".src2"}, 32'(src2), 32'(s2));
        chk({t, ".two"}, 32'(two_src), 32'(!ins[25] || str));
        chk({t, ".rn"}, val_rn, rd(ins[19:16]));
        chk({t, ".rm"}, val_rm, rd(s2));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            dp_ok[i] = 0; dp_wb[i] = 0; dp_cmd[i] = 4'd0;
        end
        dp(4'b1101, 4'b0001, 1); dp(4'b1111, 4'b1001, 1);
        dp(4'b0100, 4'b0010, 1); dp(4'b0101, 4'b0011, 1);
        dp(4'b0010, 4'b0100, 1); dp(4'b0110, 4'b0101, 1);
        dp(4'b0000, 4'b0110, 1); dp(4'b1100, 4'b0111, 1);
        dp(4'b0001, 4'b1000, 1); dp(4'b1010, 4'b0100, 0);
        dp(4'b1000, 4'b0110, 0);

        // instr, nzcv, hz, cmd, wb, mr, mw, b, s, two, rn, rm
        tbl.push_back('{32'hE0821003, 4'h0, 0, 4'h2, 1, 0, 0, 0, 0, 1, 2, 3});
        tbl.push_back('{32'hE3A00014, 4'h0, 0, 4'h1, 1, 0, 0, 0, 0, 0, 0, 4});
        tbl.push_back('{32'h04921004, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 2, 4});
        tbl.push_back('{32'h04921004, 4'h4, 0, 4'h2, 1, 1, 0, 0, 0, 1, 2, 4});
        tbl.push_back('{32'hE4821004, 4'h0, 0, 4'h2, 0, 0, 1, 0, 0, 1, 2, 1});
        tbl.push_back('{32'hE4821004, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0, 1, 2, 1});
        tbl.push_back('{32'hEA000002, 4'h0, 0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 2});
        tbl.push_back('{32'h00000000, 4'hF, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{32'hE1530004, 4'h0, 0, 4'h4, 0, 0, 0, 0, 1, 1, 3, 4});
        tbl.push_back('{32'hF0521003, 4'hF, 0, 4'h0, 0, 0, 0, 0, 0, 1, 2, 3});
        tbl.push_back('{32'hC0821003, 4'h9, 0, 4'h2, 1, 0, 0, 0, 0, 1, 2, 3});
        tbl.push_back('{32'hB0821003, 4'h9, 0, 4'h0, 0, 0, 0, 0, 0, 1, 2, 3});
        tbl.push_back('{32'h80821003, 4'h2, 0, 4'h2, 1, 0, 0, 0, 0, 1, 2, 3});
        tbl.push_back('{32'hE1621001, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 2, 1});
        tbl.push_back('{32'hEC000000, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0});

        rst = 1; pc_in = 0; instruction_in = 0; status_in = 0;
        hazard = 0; wb_en_in = 1; wb_dest = 4'd2;
        wb_value = 32'hDEADBEEF;
        model_reset();

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            instruction_in = {12'hE08, 4'(i), 16'h1003};
            #1;
            chk($sformatf("rst.r%0d", i), val_rn, 32'(i));
        end
        chk("rst.rm_nobyp", val_rm, 32'd3);

        @(negedge clk);
        rst = 0; wb_en_in = 0;
        foreach (tbl[i]) begin
            @(negedge clk);
            instruction_in = tbl[i].instr;
            status_in = tbl[i].st;
            hazard = tbl[i].hz;
            pc_in = $urandom;
            #1;
            chk($sformatf("v%0d.cmd", i), 32'(exe_cmd), 32'(tbl[i].cmd));
            chk($sformatf("v%0d.wb", i), 32'(wb_en), 32'(tbl[i].wb));
            chk($sformatf("v%0d.mr", i), 32'(mem_r_en), 32'(tbl[i].mr));
            chk($sformatf("v%0d.mw", i), 32'(mem_w_en), 32'(tbl[i].mw));
            chk($sformatf("v%0d.b", i), 32'(b), 32'(tbl[i].br));
            chk($sformatf("v%0d.s", i), 32'(s), 32'(tbl[i].sf));
            chk($sformatf("v%0d.two", i), 32'(two_src), 32'(tbl[i].two));
            chk($sformatf("v%0d.rn", i), val_rn, tbl[i].rn);
            chk($sformatf("v%0d.rm", i), val_rm, tbl[i].rm);
            check_all($sformatf("v%0d", i));
        end

        @(negedge clk);
        hazard = 0; status_in = 0;
        instruction_in = 32'hEA000002;
        #1;
        chk("br.si", 32'(signed_imm_24), 32'h000002);
        instruction_in = 32'hE3A00014;
        #1;
        chk("mov.sh", 32'(shift_operand), 32'h014);

        @(negedge clk);
        instruction_in = 32'hE0821003;
        wb_en_in = 1; wb_dest = 4'd2; wb_value = 32'hDEADBEEF;
        #1;
        chk("byp.rn", val_rn, 32'hDEADBEEF);
        check_all("byp");
        tick();
        wb_en_in = 0;
        #1;
        chk("byp.hold", val_rn, 32'hDEADBEEF);

        @(negedge clk);
        hazard = 1;
        wb_en_in = 1; wb_dest = 4'd3; wb_value = 32'h12345678;
        #1;
        chk("stall.cmd", 32'(exe_cmd), 32'd0);
        chk("stall.wb", 32'(wb_en), 32'd0);
        tick();
        wb_en_in = 0; hazard = 0;
        #1;
        chk("stall.commit", val_rm, 32'h12345678);

        wb_en_in = 1; wb_dest = 4'd15; wb_value = 32'hCAFEF00D;
        tick();
        wb_en_in = 0;
        instruction_in = 32'hE08F1003;
        #1;
        chk("r15.rn", val_rn, 32'hCAFEF00D);

        instruction_in = 32'hE0821003;
        #1;
        rst = 1;
        #1;
        chk("arst.rn", val_rn, 32'd2);
        chk("arst.rm", val_rm, 32'd3);
        rst = 0;
        model_reset();
        #1;
        chk("arst.after", val_rn, 32'd2);
        check_all("arst");

        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[31:28] = 4'hE;
            if ($urandom_range(0, 31) == 0) r = 32'd0;
            instruction_in = r;
            pc_in = $urandom;
            status_in = 4'($urandom_range(0, 15));
            hazard = ($urandom_range(0, 7) == 0);
            wb_en_in = 1'($urandom_range(0, 1));
            wb_dest = ($urandom_range(0, 1) != 0) ? r[19:16]
                                                 : 4'($urandom_range(0, 15));
            wb_value = $urandom;
            #1;
            check_all($sformatf("rnd%0d", k));
            @(posedge clk);
            if (wb_en_in) m_regs[wb_dest] = wb_value;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
